fifo_wr_arbiter: RTL and testbench

- Shares the write port of one synchronous FIFO among N_REQ producers.
- Grants producers round-robin with a bounded burst per grant and forwards the granted producer's data to the FIFO write interface.
- Tracks FIFO free space with a local credit counter, so no write is issued into a full FIFO despite the FIFO's lagging full flag.
- Sits between producer blocks and the FIFO instance; the consumer side returns credits with a read pulse.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/rr_picker.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO write-side controllers and the FIFO instance they feed.
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefDepth     = 64;

  // Ceiling log2; clog2(1) is 0, so callers needing a 1-bit minimum must guard it.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req_i starting at ptr_i, wrapping modulo N.
module rr_picker import fifo_ctrl_pkg::*; #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [clog2(N)-1:0]   ptr_i,
  output logic                  found_o,
  output logic [clog2(N)-1:0]   idx_o
);

  localparam int unsigned IdxW = clog2(N);

  always_comb begin
    logic [IdxW-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among N_REQ producers, with
// local credit tracking so writes never land in a full FIFO.
module fifo_wr_arbiter import fifo_ctrl_pkg::*; #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full,
  input  logic                          fifo_rd_done,
  output logic [clog2(N_REQ)-1:0]       grant_id,
  output logic                          busy,
  output logic [clog2(DEPTH+1)-1:0]     credits,
  output logic                          credit_err
);

  localparam int unsigned IdxW  = clog2(N_REQ);
  localparam int unsigned CredW = clog2(DEPTH + 1);
  localparam int unsigned BeatW = clog2(MAX_BURST + 1);
  localparam logic [CredW-1:0] CredMax  = CredW'(DEPTH);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(MAX_BURST - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_REQ - 1);

  state_e                  state_q;
  logic [CredW-1:0]        credits_q, credits_d;
  logic                    err_q, err_d;
  logic [IdxW-1:0]         rr_ptr_q, grant_q;
  logic [BeatW-1:0]        beat_q;
  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   din_q;

  logic [DATA_WIDTH-1:0]   req_word [N_REQ];
  logic                    can_write, hs, burst_end, pick_found;
  logic [IdxW-1:0]         pick_idx, rr_next;

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .N (N_REQ)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign can_write = (credits_q != '0) && !fifo_full;
  assign hs        = (state_q == StBurst) && can_write && req_valid[grant_q];
  assign burst_end = !can_write || !req_valid[grant_q] || (hs && (beat_q == BeatLast));
  assign rr_next   = (grant_q == IdxLast) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == StBurst && can_write) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  // A simultaneous write and return cancel out; a return at full credit is an accounting error.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (hs && !fifo_rd_done) begin
      credits_d = credits_q - 1'b1;
    end else if (!hs && fifo_rd_done) begin
      if (credits_q == CredMax) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      credits_q <= CredMax;
      err_q     <= 1'b0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      beat_q    <= '0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
      wr_en_q   <= hs;
      if (hs) begin
        din_q <= req_word[grant_q];
      end
      unique case (state_q)
        StIdle: begin
          if (pick_found && can_write) begin
            grant_q <= pick_idx;
            beat_q  <= '0;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (hs) begin
            beat_q <= beat_q + 1'b1;
          end
          if (burst_end) begin
            state_q  <= StIdle;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q == StBurst);
  assign credits    = credits_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: bench-side producers and consumer, credit/fairness model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int MB    = 4;
  localparam int FairBound = (N - 1) * (MB + 1) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic            fifo_full = 1'b0;
  logic            fifo_rd_done = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic [6:0]      credits;
  logic            credit_err;

  fifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .fifo_full    (fifo_full),
    .fifo_rd_done (fifo_rd_done),
    .grant_id     (grant_id),
    .busy         (busy),
    .credits      (credits),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
  endfunction

  // Producer word queues, scoreboard, write log and reference state.
  logic [DW-1:0] pq [N][$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wlog_d [$];
  int            wlog_c [$];
  logic          wlog_b [$];
  int            cyc = 0;
  int            n_wr = 0;
  int            credits_m = DEPTH;
  logic          err_m = 1'b0;
  logic [N-1:0]  hs_mask = '0;
  int            last_p = -1;
  int            run_len = 0;
  int            waits [N];
  int            gate = 0, rd_rate = 0, full_rate = 0;
  logic          force_rd = 1'b0;

  // Monitor: retire writes against the scoreboard, then record this cycle's handshake.
  always @(negedge clk) begin : monitor
    logic [N-1:0] hs;
    logic         canw;
    int           p;
    cyc++;
    if (fifo_wr_en === 1'b1) begin
      check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("wr_data", 32'(fifo_din), 32'(exp_q.pop_front()));
      n_wr++;
      wlog_d.push_back(fifo_din);
      wlog_c.push_back(cyc);
      wlog_b.push_back(busy);
    end
    if (rst) begin
      exp_q.delete();
      credits_m = DEPTH;
      err_m     = 1'b0;
      hs_mask   = '0;
      last_p    = -1;
      run_len   = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      check("credits", 32'(credits), 32'(credits_m));
      check("credit_err", 32'(credit_err), 32'(err_m));
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      canw = (credits_m != 0) && !fifo_full;
      if (!canw) check("ready_gated", 32'(req_ready), 32'd0);
      hs = req_valid & req_ready;
      hs_mask = hs;
      p = -1;
      for (int i = 0; i < N; i++) if (hs[i]) p = i;
      if (p >= 0) begin
        check("burst_boundary", 32'(last_p < 0 || last_p == p), 32'd1);
        run_len = (last_p == p) ? run_len + 1 : 1;
        check("burst_len", 32'(run_len <= MB), 32'd1);
        exp_q.push_back(req_data[p*DW +: DW]);
      end
      last_p = p;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          if (req_valid[i]) check("fair_wait", 32'(waits[i] <= FairBound), 32'd1);
          waits[i] = 0;
        end else if (req_valid[i] && canw) waits[i]++;
        else waits[i] = 0;
      end
      if (p >= 0 && !fifo_rd_done) credits_m--;
      else if (p < 0 && fifo_rd_done) begin
        if (credits_m == DEPTH) err_m = 1'b1;
        else credits_m++;
      end
    end
  end

  // One clock of producer/consumer behaviour; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_valid[i] = (pq[i].size() > 0) && (gate == 0 || $urandom_range(99) >= gate);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    fifo_rd_done = force_rd ||
                   (rd_rate > 0 && credits_m < DEPTH && $urandom_range(99) < rd_rate);
    force_rd = 1'b0;
    fifo_full = (full_rate > 0) && ($urandom_range(99) < full_rate);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    req_valid = '0;
    req_data = '0;
    fifo_rd_done = 1'b0;
    fifo_full = 1'b0;
    gate = 0;
    rd_rate = 0;
    full_rate = 0;
    force_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_wr = 0;
    wlog_d.delete();
    wlog_c.delete();
    wlog_b.delete();
  endtask

  task automatic run_until(input int target, input int budget);
    for (int k = 0; k < budget && n_wr < target; k++) tick();
  endtask

  initial begin : stim
    logic found;
    int   n0;
    int   total;

    // 1: single producer, six words, burst limit splits them 4 + 2 with one bubble.
    do_reset();
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_credits", 32'(credits), 32'd64);
    check("rst_grant", 32'(grant_id), 32'd0);
    for (int k = 0; k < 6; k++) pq[2].push_back(8'hA0 + 8'(k));
    run_until(6, 60);
    repeat (4) tick();
    check("t1_count", 32'(n_wr), 32'd6);
    if (wlog_c.size() >= 6) begin
      for (int k = 0; k < 6; k++) check("t1_data", 32'(wlog_d[k]), 32'(8'hA0 + k));
      for (int k = 0; k < 5; k++) check("t1_gap", 32'(wlog_c[k+1] - wlog_c[k]), (k == 3) ? 2 : 1);
      check("t1_busy_in_burst", 32'(wlog_b[0]), 32'd1);
      check("t1_busy_dropped", 32'(wlog_b[3]), 32'd0);
    end
    check("t1_credits", 32'(credits), 32'd58);

    // 2: all producers valid from reset; grants rotate 0,1,2,3,0 in bursts of four.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) pq[i].push_back({4'(i), 4'(k)});
    run_until(20, 200);
    check("t2_count", 32'(n_wr >= 20), 32'd1);
    if (wlog_d.size() >= 20)
      for (int k = 0; k < 20; k++) check("t2_order", 32'(wlog_d[k][7:4]), 32'((k / 4) % N));

    // 3: credit exhaustion, then a single returned credit allows exactly one more write.
    do_reset();
    for (int k = 0; k < 100; k++) pq[0].push_back(8'(k));
    repeat (150) tick();
    check("t3_count", 32'(n_wr), 32'd64);
    check("t3_credits", 32'(credits), 32'd0);
    check("t3_ready", 32'(req_ready), 32'd0);
    force_rd = 1'b1;
    repeat (30) tick();
    check("t3_count_after", 32'(n_wr), 32'd65);
    check("t3_credits_after", 32'(credits), 32'd0);

    // 4: write and credit return in the same cycle leave the count unchanged.
    do_reset();
    for (int k = 0; k < 54; k++) pq[1].push_back(8'(k));
    run_until(54, 200);
    repeat (4) tick();
    check("t4_credits_pre", 32'(credits), 32'd10);
    pq[1].push_back(8'h5A);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      #1;
      if (req_valid[1] && req_ready[1]) begin
        fifo_rd_done = 1'b1;
        found = 1'b1;
      end
    end
    check("t4_handshake_seen", 32'(found), 32'd1);
    tick();
    check("t4_credits", 32'(credits), 32'd10);
    check("t4_wr_en", 32'(fifo_wr_en), 32'd1);
    check("t4_din", 32'(fifo_din), 32'h5A);

    // 5: credit return at full credit is ignored and latches the error until reset.
    do_reset();
    repeat (3) tick();
    force_rd = 1'b1;
    tick();
    tick();
    check("t5_credits", 32'(credits), 32'd64);
    check("t5_err", 32'(credit_err), 32'd1);
    repeat (5) tick();
    check("t5_err_sticky", 32'(credit_err), 32'd1);
    do_reset();
    check("t5_err_cleared", 32'(credit_err), 32'd0);

    // 6: reset on the second beat of a burst abandons it.
    do_reset();
    for (int k = 0; k < 8; k++) pq[3].push_back(8'hC0 + 8'(k));
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (req_valid[3] && req_ready[3]) found = 1'b1;
    end
    check("t6_burst_started", 32'(found), 32'd1);
    tick();
    check("t6_mid_burst", 32'(req_valid[3] && req_ready[3]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pq[3].delete();
    req_valid = '0;
    check("t6_wr_en", 32'(fifo_wr_en), 32'd0);
    check("t6_credits", 32'(credits), 32'd64);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    n0 = n_wr;
    repeat (20) tick();
    check("t6_no_more_writes", 32'(n_wr), 32'(n0));

    // 7: randomized traffic with valid gaps, credit returns and full-flag glitches.
    do_reset();
    total = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 50; k++) begin
        pq[i].push_back(8'($urandom));
        total++;
      end
    gate = 25;
    rd_rate = 25;
    full_rate = 10;
    for (int k = 0; k < 4000 && n_wr < total; k++) tick();
    gate = 0;
    rd_rate = 0;
    full_rate = 0;
    repeat (3) tick();
    check("t7_all_written", 32'(n_wr), 32'(total));
    check("t7_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
